// File: rtl/demux1_4_4bit_buf_pkg.sv
// ============================================================================
// Module      : demux1_4_4bit_buf_pkg
// Description : Lane-count, width and select constants shared by the nibble
//               distributor and the 4:1 nibble selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux1_4_4bit_buf_pkg;

   localparam int c_lanes = 4;
   localparam int c_width = 4;
   localparam int c_sel_w = 2;

   typedef logic [c_width-1:0] nibble_t;
   typedef logic [c_sel_w-1:0] sel_t;
   typedef logic [c_lanes-1:0] lane_mask_t;

   function automatic logic [2:0] popcount4(input lane_mask_t v);
      logic [2:0] sum;
      sum = 3'd0;
      for (int i = 0; i < c_lanes; i++) begin
         sum = sum + {2'b00, v[i]};
      end
      return sum;
   endfunction

endpackage

`default_nettype wire

// File: rtl/demux1_4_4bit_buf_lane_reg_4bit.sv
// ============================================================================
// Module      : lane_reg_4bit
// Description : One output lane: valid flag plus data register, fill wins
//               over drain so a same-cycle drain+fill passes data through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_reg_4bit
   import demux1_4_4bit_buf_pkg::*;
#(
   parameter int WIDTH = c_width
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_fill,
   input  logic             i_drain,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   // Draining an empty lane just keeps it empty, so i_drain needs no gating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_fill) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_drain) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/demux1_4_4bit_buf.sv
// ============================================================================
// Module      : demux1_4_4bit_buf
// Description : Buffered 1-to-4 nibble distributor with per-lane valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux1_4_4bit_buf
   import demux1_4_4bit_buf_pkg::*;
#(
   parameter int WIDTH = c_width,
   parameter int LANES = c_lanes
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [c_sel_w-1:0] in_sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   out0,
   output logic [WIDTH-1:0]   out1,
   output logic [WIDTH-1:0]   out2,
   output logic [WIDTH-1:0]   out3,
   output logic [LANES-1:0]   out_valid,
   input  logic [LANES-1:0]   out_ready,
   output logic [2:0]         occupancy
);

   logic [LANES-1:0] w_v;
   logic [LANES-1:0] w_fill;
   logic [WIDTH-1:0] w_d [LANES];
   logic             w_accept;

   // Target lane is free if empty or being emptied this very cycle.
   assign in_ready = ~w_v[in_sel] | out_ready[in_sel];
   assign w_accept = in_valid & in_ready;
   assign w_fill   = w_accept ? (LANES'(1) << in_sel) : '0;

   generate
      for (genvar k = 0; k < LANES; k++) begin : g_lane
         lane_reg_4bit #(
            .WIDTH (WIDTH)
         ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_fill  (w_fill[k]),
            .i_drain (out_ready[k]),
            .i_data  (in_data),
            .o_valid (w_v[k]),
            .o_data  (w_d[k])
         );
      end
   endgenerate

   assign out0      = w_d[0];
   assign out1      = w_d[1];
   assign out2      = w_d[2];
   assign out3      = w_d[3];
   assign out_valid = w_v;
   assign occupancy = popcount4(w_v);

endmodule

`default_nettype wire

// File: tb/tb_demux1_4_4bit_buf.sv
// ============================================================================
// Module      : tb_demux1_4_4bit_buf
// Description : Table-driven check of demux1_4_4bit_buf plus reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux1_4_4bit_buf;

   logic       clk;
   logic       rst;
   logic [3:0] in_data;
   logic [1:0] in_sel;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] out0, out1, out2, out3;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [2:0] occupancy;

   int checks = 0;
   int errors = 0;

   demux1_4_4bit_buf dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out0      (out0),
      .out1      (out1),
      .out2      (out2),
      .out3      (out3),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  data;
      logic [1:0]  sel;
      logic        valid;
      logic [3:0]  ordy;
      logic        exp_rdy;
      logic [3:0]  exp_v;
      logic [15:0] exp_d;   // {out3,out2,out1,out0} after the edge
      logic [2:0]  exp_occ;
   } vec_t;

   vec_t vecs [24];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [3:0] v,
                            input logic [15:0] d, input logic [2:0] occ);
      chk({tag, " out_valid"}, {12'h0, out_valid}, {12'h0, v});
      chk({tag, " outs"}, {out3, out2, out1, out0}, d);
      chk({tag, " occupancy"}, {13'h0, occupancy}, {13'h0, occ});
   endtask

   function automatic vec_t mk(input logic [3:0] data, input logic [1:0] sel,
                               input logic valid, input logic [3:0] ordy,
                               input logic rdy, input logic [3:0] v,
                               input logic [15:0] d, input logic [2:0] occ);
      vec_t t;
      t.data = data; t.sel = sel; t.valid = valid; t.ordy = ordy;
      t.exp_rdy = rdy; t.exp_v = v; t.exp_d = d; t.exp_occ = occ;
      return t;
   endfunction

   initial begin
      //          data  sel valid ordy     rdy  v        d        occ
      // scatter A,B,C,D
      vecs[0]  = mk(4'hA, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 16'h000A, 3'd1);
      vecs[1]  = mk(4'hB, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0011, 16'h00BA, 3'd2);
      vecs[2]  = mk(4'hC, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0111, 16'h0CBA, 3'd3);
      vecs[3]  = mk(4'hD, 2'd3, 1'b1, 4'b0000, 1'b1, 4'b1111, 16'hDCBA, 3'd4);
      // drain all, then backpressure on lane 1
      vecs[4]  = mk(4'h0, 2'd0, 1'b0, 4'b1111, 1'b1, 4'b0000, 16'hDCBA, 3'd0);
      vecs[5]  = mk(4'h5, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0010, 16'hDC5A, 3'd1);
      vecs[6]  = mk(4'h9, 2'd1, 1'b1, 4'b0000, 1'b0, 4'b0010, 16'hDC5A, 3'd1);
      vecs[7]  = mk(4'h9, 2'd1, 1'b1, 4'b0000, 1'b0, 4'b0010, 16'hDC5A, 3'd1);
      vecs[8]  = mk(4'h9, 2'd1, 1'b1, 4'b0010, 1'b1, 4'b0010, 16'hDC9A, 3'd1);
      vecs[9]  = mk(4'h0, 2'd1, 1'b0, 4'b0010, 1'b1, 4'b0000, 16'hDC9A, 3'd0);
      // streaming through lane 3
      vecs[10] = mk(4'h1, 2'd3, 1'b1, 4'b1000, 1'b1, 4'b1000, 16'h1C9A, 3'd1);
      vecs[11] = mk(4'h2, 2'd3, 1'b1, 4'b1000, 1'b1, 4'b1000, 16'h2C9A, 3'd1);
      vecs[12] = mk(4'h3, 2'd3, 1'b1, 4'b1000, 1'b1, 4'b1000, 16'h3C9A, 3'd1);
      vecs[13] = mk(4'h4, 2'd3, 1'b1, 4'b1000, 1'b1, 4'b1000, 16'h4C9A, 3'd1);
      vecs[14] = mk(4'h0, 2'd3, 1'b0, 4'b1000, 1'b1, 4'b0000, 16'h4C9A, 3'd0);
      // simultaneous drain of lane 2 and drain+fill of lane 0
      vecs[15] = mk(4'h7, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 16'h4C97, 3'd1);
      vecs[16] = mk(4'hE, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0101, 16'h4E97, 3'd2);
      vecs[17] = mk(4'h3, 2'd0, 1'b1, 4'b0101, 1'b1, 4'b0001, 16'h4E93, 3'd1);
      vecs[18] = mk(4'h0, 2'd0, 1'b0, 4'b0001, 1'b1, 4'b0000, 16'h4E93, 3'd0);
      // no-effect: ready on empty lanes, in_valid=0 with varying in_sel
      vecs[19] = mk(4'hF, 2'd1, 1'b0, 4'b1111, 1'b1, 4'b0000, 16'h4E93, 3'd0);
      vecs[20] = mk(4'hF, 2'd2, 1'b0, 4'b0000, 1'b1, 4'b0000, 16'h4E93, 3'd0);
      vecs[21] = mk(4'hF, 2'd3, 1'b0, 4'b0000, 1'b1, 4'b0000, 16'h4E93, 3'd0);
      // in_ready reflects a full lane even with in_valid low
      vecs[22] = mk(4'h6, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0001, 16'h4E96, 3'd1);
      vecs[23] = mk(4'h8, 2'd0, 1'b0, 4'b0000, 1'b0, 4'b0001, 16'h4E96, 3'd1);

      rst       = 1'b1;
      in_data   = 4'h0;
      in_sel    = 2'd0;
      in_valid  = 1'b0;
      out_ready = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      chk_state("reset", 4'b0000, 16'h0000, 3'd0);
      chk("reset in_ready", {15'h0, in_ready}, 16'h0001);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         in_data   = vecs[i].data;
         in_sel    = vecs[i].sel;
         in_valid  = vecs[i].valid;
         out_ready = vecs[i].ordy;
         #1;
         chk($sformatf("v%0d in_ready", i), {15'h0, in_ready}, {15'h0, vecs[i].exp_rdy});
         @(posedge clk);
         #1;
         chk_state($sformatf("v%0d", i), vecs[i].exp_v, vecs[i].exp_d, vecs[i].exp_occ);
      end

      // Fill lane 2 so lanes 0 and 2 are full, then reset mid-cycle.
      @(negedge clk);
      in_data   = 4'h8;
      in_sel    = 2'd2;
      in_valid  = 1'b1;
      out_ready = 4'b0000;
      @(posedge clk);
      #1;
      chk_state("prefill", 4'b0101, 16'h4896, 3'd2);
      in_sel   = 2'd0;
      in_data  = 4'hB;
      #2;
      chk("prefill in_ready", {15'h0, in_ready}, 16'h0000);
      rst = 1'b1;
      #1;
      chk_state("async reset", 4'b0000, 16'h0000, 3'd0);
      chk("async reset in_ready", {15'h0, in_ready}, 16'h0001);
      // in_valid stays high across an edge while rst is held: nothing accepted
      @(posedge clk);
      #1;
      chk_state("reset held", 4'b0000, 16'h0000, 3'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_state("post reset", 4'b0001, 16'h000B, 3'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/demux1_4_4bit_buf.md
# demux1_4_4bit_buf

Buffered 1-to-4 distributor for 4-bit values: accepts one nibble per cycle on a valid/ready input, steers it to the output lane chosen by a 2-bit select, and holds it in that lane's register until the lane consumer takes it. It is the write/scatter counterpart of the 4:1 nibble selector used in the datapath. It feeds four independent consumers (e.g. per-field latches, per-unit operand slots) from one producer without dropping or duplicating data.

## Interface
Parameters:
- WIDTH, 4: data width per lane. Only 4 is supported and verified.
- LANES, 4: number of output lanes. Fixed at 4, with a 2-bit select.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  4  nibble to distribute.
- in_sel  input  2  destination lane, 0..3.
- in_valid  input  1  producer has in_data/in_sel.
- in_ready  output  1  distributor accepts this cycle.
- out0, out1, out2, out3  output  4 each  lane holding registers.
- out_valid  output  4  bit k set = lane k holds unconsumed data.
- out_ready  input  4  bit k set = lane k consumer takes data this cycle.
- occupancy  output  3  number of full lanes, 0..4.

## Operation
- Per lane k: valid flag v[k] and data register d[k]; outk = d[k]; out_valid[k] = v[k].
- Lane drain: when v[k] && out_ready[k], the lane is consumed at the edge.
- in_ready = ~v[in_sel] | out_ready[in_sel]. The target lane is empty, or is being drained this cycle.
  - Combinational from state, in_sel and out_ready.
  - Independent of in_valid.
- Accept: when in_valid && in_ready, set d[in_sel] <= in_data and v[in_sel] <= 1 at the edge.
- Next state of each lane:
  - Accept into lane k (with or without a simultaneous drain of k): v=1, d=new data. Data is replaced, never lost, because the old value was consumed that cycle.
  - Drain of k with no accept into k: v=0. d holds its last value.
  - Otherwise: no change.
- Lanes other than in_sel drain independently in the same cycle.
- out_ready[k] while v[k]=0 has no effect.
- in_valid=0: no lane is written, whatever in_sel is.
- in_sel is sampled only when in_valid=1. There are no X/illegal encodings (2 bits cover all 4 lanes).
- occupancy = popcount(v). It is combinational from registered flags and always equals the number of set out_valid bits.
- Backpressure: if the target lane is full and not draining, the input stalls (in_ready=0). It does not fall through to another lane.
- The producer must hold in_data/in_sel/in_valid stable while in_valid && ~in_ready.

## Timing
- Reset (asynchronous, immediate on rst rising, held while rst=1):
  - v=4'b0000, all d=4'h0.
  - out_valid=0, occupancy=0.
  - in_ready=1 (all lanes empty).
- Reset mid-operation discards all held data. No accept occurs on an edge where rst=1.
- Latency: data accepted at edge N appears on outk with out_valid[k]=1 after edge N (cycle N+1).
- Throughput:
  - One accept per cycle.
  - A single lane sustains one nibble per cycle when its consumer holds out_ready[k]=1 (pass-through via simultaneous drain+fill).
- All outputs except in_ready are registered or a popcount of registers. in_ready is the only combinational input-to-output path.

## Structure
- Shared package/header holds the lane-count, width and select-width constants (LANES=4, WIDTH=4, SEL_W=2) used by this block and the 4:1 selector.
- Natural sub-module: lane_reg_4bit, one lane's valid flag plus data register with fill/drain inputs, instantiated four times.
- Top level contains:
  - the 2-to-4 select decode gated by accept;
  - the in_ready mux;
  - the popcount.

## Test plan
- Reset then idle: assert rst mid-run with lanes 0 and 2 full -> out_valid=0000, occupancy=0, out0..out3=0, in_ready=1 immediately.
- Scatter: out_ready=0000, send A,B,C,D to sel 0,1,2,3 on consecutive cycles -> out0..3=A,B,C,D, out_valid=1111, occupancy=4 one cycle after the last accept.
- Backpressure: lane 1 holds 5, out_ready=0000, present 9 to sel 1 -> in_ready=0 and out1 stays 5. Raise out_ready[1] -> in_ready=1 same cycle, next cycle out1=9, out_valid[1]=1.
- Streaming: out_ready[3]=1 held, send 1,2,3,4 to sel 3 back to back -> in_ready stays 1, out3 shows 1,2,3,4 on successive cycles, occupancy=1 throughout.
- Simultaneous events: lane 0 full with 7, lane 2 full with E. In one cycle, drain lane 2 and accept 3 into lane 0 while out_ready[0]=1 -> lane 0=3, lane 2 empty, occupancy=1.
- No-effect cases: out_ready=1111 with all lanes empty, and in_valid=0 with toggling in_sel -> no state change, occupancy=0.
